// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcode and
// state encodings plus the default operand width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_if.sv
// Issue / MTHI / MTLO bundle between the controller and the muldiv unit.
// The controller drives the request side (master); the unit drives busy,
// done and the architectural HI/LO view (slave).
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath.
// i_div=0: radix-2 shift-add multiply step. {i_wh,i_wl} is the partial
//          product with the remaining multiplier bits in i_wl; i_opnd is
//          the multiplicand.
// i_div=1: restoring-division step. i_wh is the partial remainder, i_wl
//          shifts the dividend out at the top and the quotient in at the
//          bottom; i_opnd is the divisor.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_wh,
    input  logic [WIDTH-1:0] i_wl,
    input  logic [WIDTH-1:0] i_opnd,
    output logic [WIDTH-1:0] o_wh,
    output logic [WIDTH-1:0] o_wl
);
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic           w_ge;

    // Add-or-pass for multiply, trial subtract for divide
    always_comb begin
        o_wh    = i_wh;
        o_wl    = i_wl;
        w_sum   = {1'b0, i_wh} + (i_wl[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_wh, i_wl[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        if (i_div) begin
            // Remainder stays below the divisor (or below 2^k after k steps
            // when dividing by zero), so WIDTH bits always hold it.
            o_wh = w_ge ? WIDTH'(w_shift - {1'b0, i_opnd}) : w_shift[WIDTH-1:0];
            o_wl = {i_wl[WIDTH-2:0], w_ge};
        end else begin
            o_wh = w_sum[WIDTH:1];
            o_wl = {w_sum[0], i_wl[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take WIDTH RUN cycles plus one FIX cycle; MTHI/MTLO
// writes are accepted while idle.
// Optional build macro MULDIV_ACC_EN enables MADD/MADDU (multiply and
// accumulate into {HI,LO}); without it those opcodes are ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_wh;
    logic [WIDTH-1:0]   r_wl;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_div;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_busy;
    logic               w_op_ok;
    logic               w_sgn_op;
    logic               w_div_op;
    logic               w_issue;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_wh_nxt;
    logic [WIDTH-1:0]   w_wl_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [2*WIDTH-1:0] w_result;
`ifdef MULDIV_ACC_EN
    logic               w_acc_op;
    logic               r_acc;
`endif

    // Opcode decode: legality, signedness and multiply/divide selection
    always_comb begin
        w_op_ok  = 1'b0;
        w_sgn_op = 1'b0;
        w_div_op = 1'b0;
`ifdef MULDIV_ACC_EN
        w_acc_op = 1'b0;
`endif
        case (bus.op)
            OP_MULT:  begin w_op_ok = 1'b1; w_sgn_op = 1'b1; end
            OP_MULTU: begin w_op_ok = 1'b1; end
            OP_DIV:   begin w_op_ok = 1'b1; w_sgn_op = 1'b1; w_div_op = 1'b1; end
            OP_DIVU:  begin w_op_ok = 1'b1; w_div_op = 1'b1; end
`ifdef MULDIV_ACC_EN
            OP_MADD:  begin w_op_ok = 1'b1; w_sgn_op = 1'b1; w_acc_op = 1'b1; end
            OP_MADDU: begin w_op_ok = 1'b1; w_acc_op = 1'b1; end
`endif
            default:  ;
        endcase
    end

    assign w_busy  = (r_state != ST_IDLE);
    assign w_issue = bus.start && !w_busy && w_op_ok;
    assign w_sa    = w_sgn_op & bus.a[WIDTH-1];
    assign w_sb    = w_sgn_op & bus.b[WIDTH-1];
    assign w_mag_a = w_sa ? -bus.a : bus.a;
    assign w_mag_b = w_sb ? -bus.b : bus.b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_div),
        .i_wh   (r_wh),
        .i_wl   (r_wl),
        .i_opnd (r_opnd),
        .o_wh   (w_wh_nxt),
        .o_wl   (w_wl_nxt)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: IDLE -> RUN on issue, WIDTH RUN cycles, one FIX cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_nxt = ST_RUN;
            ST_RUN:  if (r_count == CNT_W'(WIDTH-1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction of the magnitude result. A zero divisor forces an
    // all-ones quotient regardless of sign; the remainder already equals
    // |a| and picks up the dividend's sign, giving back a.
    assign w_prod     = {r_wh, r_wl};
    assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
    assign w_quot     = r_div0 ? '1 : (r_neg_res ? -r_wl : r_wl);
    assign w_rem      = r_neg_rem ? -r_wh : r_wh;

    // Select the value committed to {HI,LO} in FIX
    always_comb begin
        w_result = w_prod_fix;
        if (r_div) begin
            w_result = {w_rem, w_quot};
        end
`ifdef MULDIV_ACC_EN
        else if (r_acc) begin
            w_result = {r_hi, r_lo} + w_prod_fix;
        end
`endif
    end

    // Working registers: latch magnitudes on issue, iterate while in RUN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= '0;
            r_wh      <= '0;
            r_wl      <= '0;
            r_opnd    <= '0;
            r_div     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
`ifdef MULDIV_ACC_EN
            r_acc     <= 1'b0;
`endif
        end else if (w_issue) begin
            r_count   <= '0;
            r_wh      <= '0;
            r_wl      <= w_mag_a;
            r_opnd    <= w_mag_b;
            r_div     <= w_div_op;
            r_neg_res <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_div0    <= w_div_op && (bus.b == '0);
`ifdef MULDIV_ACC_EN
            r_acc     <= w_acc_op;
`endif
        end else if (r_state == ST_RUN) begin
            r_count   <= r_count + CNT_W'(1);
            r_wh      <= w_wh_nxt;
            r_wl      <= w_wl_nxt;
        end
    end

    // Architectural HI/LO: result write in FIX, MTHI/MTLO only while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == ST_FIX);
            if (r_state == ST_FIX) begin
                {r_hi, r_lo} <= w_result;
            end else if (!w_busy) begin
                if (bus.hi_we) r_hi <= bus.wdata;
                if (bus.lo_we) r_lo <= bus.wdata;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases followed by randomized
// operations, all compared against an arithmetic reference of HI/LO.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: HI/LO after the operation, from plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] hi,
                                          input logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {hi, lo};
        case (op)
            3'b000: p = 64'(sa * sb);
            3'b001: p = {32'd0, a} * {32'd0, b};
            3'b010: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            3'b011: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            3'b100: p = {hi, lo} + 64'(sa * sb);
            3'b101: p = {hi, lo} + {32'd0, a} * {32'd0, b};
            default: p = {hi, lo};
        endcase
        return p;
    endfunction

    function automatic bit op_ok(input logic [2:0] op);
`ifdef MULDIV_ACC_EN
        return op <= 3'd5;
`else
        return op <= 3'd3;
`endif
    endfunction

    // Present a request for one edge, then scramble the operands
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [63:0] e;
        int          cyc;
        e = model(op, a, b, m_hi, m_lo);
        issue(op, a, b);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        wait_done(cyc);
        chk({tag, ".lat"}, 64'(cyc), 64'd33);
        chk({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
        chk({tag, ".hilo"}, {bus.hi, bus.lo}, e);
        {m_hi, m_lo} = e;
        @(posedge clk);
        #1;
        chk({tag, ".pulse"}, 64'(bus.done), 64'd0);
    endtask

    task automatic run_reserved(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                input string tag);
        int dones;
        issue(op, a, b);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
        dones = 0;
        repeat (4) begin
            if (bus.done === 1'b1) dones++;
            @(posedge clk);
            #1;
        end
        chk({tag, ".done"}, 64'(dones), 64'd0);
        chk({tag, ".hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    task automatic write_reg(input bit to_hi, input logic [31:0] d, input string tag);
        @(negedge clk);
        bus.hi_we = to_hi;
        bus.lo_we = !to_hi;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (to_hi) m_hi = d;
        else       m_lo = d;
        chk(tag, {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    initial begin
        int          cyc;
        int          dones;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        m_hi      = '0;
        m_lo      = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 64'(bus.busy), 64'd0);
        chk("rst.done", 64'(bus.done), 64'd0);
        chk("rst.hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed corner cases
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        chk("multu_max.const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'b000, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        chk("mult_neg.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg");
        chk("div_neg.const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'b011, 32'd7, 32'd0, "divu_zero");
        chk("divu_zero.const", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        chk("div_ovf.const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(3'b010, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");

        // MTHI while idle, then writes and a second start during busy
        write_reg(1'b1, 32'h0000_1234, "mthi");
        chk("mthi.const", 64'(bus.hi), 64'h1234);
        issue(3'b001, 32'd2, 32'd3);
        chk("intf.busy", 64'(bus.busy), 64'd1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD;
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        @(posedge clk);
        #1;
        bus.lo_we = 1'b0;
        bus.start = 1'b0;
        chk("intf.lo_we_ignored", 64'(bus.lo), 64'(m_lo));
        wait_done(cyc);
        chk("intf.lat", 64'(cyc), 64'd28);
        chk("intf.hilo", {bus.hi, bus.lo}, 64'd6);
        m_hi = 32'd0;
        m_lo = 32'd6;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        chk("intf.single_done", 64'(dones), 64'd0);
        chk("intf.idle", 64'(bus.busy), 64'd0);

        // Asynchronous reset in the middle of a divide
        write_reg(1'b0, 32'hCAFE, "mtlo");
        issue(3'b010, 32'hFFFF_FF9C, 32'd7);
        repeat (9) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst.busy", 64'(bus.busy), 64'd0);
        chk("arst.done", 64'(bus.done), 64'd0);
        chk("arst.hilo", {bus.hi, bus.lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        run_op(3'b001, 32'd5, 32'd5, "post_rst");
        chk("post_rst.const", {bus.hi, bus.lo}, 64'd25);

`ifdef MULDIV_ACC_EN
        write_reg(1'b1, 32'd0, "acc.pre_hi");
        write_reg(1'b0, 32'hFFFF_FFFF, "acc.pre_lo");
        run_op(3'b101, 32'd1, 32'd1, "maddu");
        chk("maddu.const", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
`else
        run_reserved(3'b100, 32'd3, 32'd4, "rsv100");
`endif
        run_reserved(3'b111, 32'd3, 32'd4, "rsv111");

        // Randomized operations against the reference
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0)
                write_reg(1'($urandom), $urandom, $sformatf("rnd%0d.wr", i));
            if (op_ok(rop)) run_op(rop, ra, rb, $sformatf("rnd%0d", i));
            else            run_reserved(rop, ra, rb, $sformatf("rnd%0d.rsv", i));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
